sample_frame_packer: RTL and testbench
======================================

# sample_frame_packer

Serial front-end that produces the packed sample bytes consumed by the moving-average filter. It receives framed 6-bit {t,y,x} samples over a strobed 1-bit serial link, checks framing and even parity, and buffers good samples in a small FIFO. It presents each sample as a packed byte {p,t,y,x} with p = 2'b11 through a valid/ready handshake, and drives 8'h00 whenever no word is valid.

## Interface
- DEPTH, 4: FIFO depth in words; power of 2, minimum 2
- PAYLOAD_W, 6: payload bits per frame, fixed at {t[1:0], y[1:0], x[1:0]}
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- ser_in  in  1  serial data bit, sampled only when ser_valid = 1
- ser_valid  in  1  bit strobe; one frame bit per cycle with ser_valid = 1
- clear_err  in  1  synchronous pulse, clears frame_err
- out_ready  in  1  downstream accepts the word this cycle
- out_valid  out  1  out_word holds a valid sample
- out_word  out  8  {2'b11, t, y, x} when out_valid = 1, else 8'h00
- frame_err  out  1  sticky; set on a parity or stop-bit error
- overflow_cnt  out  4  saturating count of good frames dropped because the FIFO was full

## Operation
- Frame is 9 strobed bits: start = 1; six payload bits LSB first (x0, x1, y0, y1, t0, t1); even parity bit; stop = 0.
- Receive FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with ser_valid = 1. Cycles with ser_valid = 0 hold all state, any length of gap.
- IDLE: ser_in = 1 goes to DATA with the bit counter cleared. ser_in = 0 is ignored (line idle).
- DATA: shift the payload LSB first. After the 6th bit, go to PARITY.
- PARITY: latch the bit, then go to STOP. Parity is good when XOR(payload, parity bit) = 0.
- STOP: always returns to IDLE.
  - Frame is good when ser_in = 0 and parity is good.
  - A good frame is pushed to the FIFO. If the FIFO is full, the frame is dropped and overflow_cnt increments, saturating at 15.
  - A bad frame is dropped and frame_err is set.
- frame_err: clear_err clears it. If a set and clear_err occur in the same cycle, set wins.
- FIFO: first-word-fall-through.
  - Pop occurs when out_valid && out_ready.
  - Push into a full FIFO in the same cycle as a pop is accepted; occupancy stays DEPTH and nothing is dropped.
  - Pointers wrap modulo DEPTH. Word order is strictly preserved.
- out_word is forced to 8'h00 whenever out_valid = 0, so downstream p gating sees 2'b00.

## Timing
- Reset values: out_valid 0, out_word 8'h00, frame_err 0, overflow_cnt 0, FSM in IDLE, FIFO empty, shift register 0.
- Reset mid-frame discards the partial frame. The next start bit begins a fresh frame.
- Latency: the edge sampling the stop bit writes the FIFO. With the FIFO empty, out_valid = 1 in the next cycle.
- out_valid and out_word are registered and hold stable until popped.
- Throughput: one frame per 9 strobed cycles, at most one push per cycle, one pop per cycle.
- frame_err and overflow_cnt update on the edge sampling the stop bit.

## Structure
- Shared package holds:
  - state enum {IDLE, DATA, PARITY, STOP}
  - FRAME_BITS = 9, START_BIT = 1'b1, STOP_BIT = 1'b0
  - P_VALID = 2'b11
  - pack function {P_VALID, payload}, shared with the filter-side bench
- One sub-module: sample_fifo, a parameterised synchronous FWFT FIFO with full, empty and count.
  - The FSM, parity, error and counter logic stay in the top.

## Test plan
- Frame 1,1,0,0,1,1,1,0,0 (x=01, y=10, t=11, parity 0, stop 0) with out_ready = 1 -> out_valid = 1 for one cycle the cycle after the stop bit, out_word = 8'hF9, frame_err = 0.
- Same frame with parity bit 1 -> no out_valid, frame_err = 1. clear_err pulse -> frame_err = 0. Clear coinciding with a new error -> frame_err stays 1.
- Same frame with ser_valid low for 3 cycles between every bit -> out_word = 8'hF9, identical result.
- out_ready = 0 and five good frames with payloads 1..5 -> 4 words stored, overflow_cnt = 1. Then out_ready = 1 -> out_word reads 8'hC1, C2, C3, C4 on consecutive cycles, then 8'h00 with out_valid = 0.
- FIFO full, and the stop bit of a 5th frame lands in the same cycle as a pop -> frame accepted, overflow_cnt unchanged, order preserved.
- Assert rst_n after the start bit and 3 data bits -> all outputs return to reset values. The next full frame decodes correctly to its expected word.

Source files
------------

// File: rtl/sample_frame_packer_pkg.sv
// Shared definitions for the serial sample front-end and the filter-side
// code that consumes its packed bytes.
//   rx_state_e  : receive FSM state encoding
//   dbg_t       : debug snapshot exported by the top (FSM state + FIFO status)
//   pack()      : builds the downstream byte {P_VALID, t, y, x}
package sample_frame_packer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int         FRAME_BITS = 9;
  localparam int         PAYLOAD_W  = 6;
  localparam logic       START_BIT  = 1'b1;
  localparam logic       STOP_BIT   = 1'b0;
  localparam logic [1:0] P_VALID    = 2'b11;

  typedef struct packed {
    rx_state_e  state;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_count;
  } dbg_t;

  function automatic logic [7:0] pack(input logic [PAYLOAD_W-1:0] payload);
    return {P_VALID, payload};
  endfunction

endpackage

// File: rtl/sample_frame_packer_if.sv
// Bundle of the serial link, control and output handshake of
// sample_frame_packer.
//   ser_in / ser_valid : strobed serial bit stream (one frame bit per strobe)
//   clear_err          : pulse clearing the sticky frame error
//   out_valid/out_ready/out_word : packed-sample output handshake
//   frame_err, overflow_cnt      : status
//
// Handshake: out_valid/out_word are driven by the packer and held stable
// until a transfer; a transfer happens on every rising clk edge where
// out_valid && out_ready. out_ready may toggle freely and does not depend on
// out_valid. While out_valid = 0, out_word reads 8'h00.
interface sample_frame_packer_if;
  import sample_frame_packer_pkg::*;

  logic       ser_in;
  logic       ser_valid;
  logic       clear_err;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_word;
  logic       frame_err;
  logic [3:0] overflow_cnt;

  // Environment side: drives the link and the ready, observes results.
  modport master (
    output ser_in, ser_valid, clear_err, out_ready,
    input  out_valid, out_word, frame_err, overflow_cnt
  );

  // Packer side.
  modport slave (
    input  ser_in, ser_valid, clear_err, out_ready,
    output out_valid, out_word, frame_err, overflow_cnt
  );

endinterface

// File: rtl/sample_frame_packer_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with a registered
// head. valid_o/data_o are flops loaded with the word that will be at the
// head after the current edge, so the output never has a combinational path
// from push/pop. data_o is zero whenever valid_o is low.
//   clk, rst_n   : clock, asynchronous active-high reset
//   push_i/push_data_i : write request and data
//   pop_i        : consume head (ignored when empty)
//   push_ok_o    : the write this cycle is accepted
//   full_o, empty_o, count_o : occupancy status
//   valid_o, data_o          : registered head word
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     push_ok_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] head_d;
  logic             pop_ok, push_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign push_ok_o = push_ok;

  always_comb begin
    pop_ok  = pop_i && valid_q;
    // A push into a full FIFO is fine when a pop frees a slot on the same edge.
    push_ok = push_i && (!full_o || pop_ok);

    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;

    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;

    // The write slot equals the next head only when the FIFO is empty after
    // the pop, so the incoming word must bypass the memory.
    head_d  = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    valid_d = (count_d != '0);
    data_d  = valid_d ? head_d : '0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/sample_frame_packer.sv
// sample_frame_packer: receives 9-bit strobed serial frames
// (start=1, x0 x1 y0 y1 t0 t1, even parity, stop=0), checks framing and
// parity, and queues good samples as packed bytes {2'b11,t,y,x} in a FWFT
// FIFO presented through a valid/ready handshake.
//   clk   : clock
//   rst_n : asynchronous reset, active HIGH (legacy name kept for the codebase)
//   bus   : sample_frame_packer_if.slave (serial link, handshake, status)
//   dbg_o : FSM state and FIFO occupancy snapshot
module sample_frame_packer
  import sample_frame_packer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sample_frame_packer_if.slave        bus,
  output dbg_t                        dbg_o
);

  rx_state_e            state_q;
  logic [2:0]           bit_cnt_q;
  logic [PAYLOAD_W-1:0] shift_q;
  logic                 par_q;
  logic                 frame_err_q;
  logic [3:0]           ovf_q;

  logic                 frame_good;
  logic                 push_req;
  logic                 push_ok;
  logic                 fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 fifo_valid;
  logic [7:0]           fifo_data;

  always_comb begin
    // Evaluated against the bit currently on the line while in STOP.
    frame_good = (bus.ser_in == STOP_BIT) && ((^shift_q ^ par_q) == 1'b0);
    push_req   = bus.ser_valid && (state_q == STOP) && frame_good;
  end

  // Receive FSM plus error/overflow status; everything advances only on strobes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      if (bus.clear_err) frame_err_q <= 1'b0;
      if (bus.ser_valid) begin
        case (state_q)
          IDLE: begin
            if (bus.ser_in == START_BIT) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {bus.ser_in, shift_q[PAYLOAD_W-1:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(PAYLOAD_W-1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bus.ser_in;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            // Written after the clear above so a new error wins over clear_err.
            if (!frame_good) frame_err_q <= 1'b1;
            else if (!push_ok && (ovf_q != 4'hF)) ovf_q <= ovf_q + 4'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_req),
    .push_data_i (pack(shift_q)),
    .pop_i       (bus.out_ready),
    .push_ok_o   (push_ok),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data)
  );

  assign bus.out_valid    = fifo_valid;
  assign bus.out_word     = fifo_data;
  assign bus.frame_err    = frame_err_q;
  assign bus.overflow_cnt = ovf_q;

  always_comb begin
    dbg_o            = '0;
    dbg_o.state      = state_q;
    dbg_o.fifo_empty = fifo_empty;
    dbg_o.fifo_full  = fifo_full;
    dbg_o.fifo_count = 8'(fifo_count);
  end

endmodule

// File: tb/tb_sample_frame_packer.sv
module tb_sample_frame_packer;
  import sample_frame_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  dbg_t dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sample_frame_packer_if bus_if ();

  sample_frame_packer #(.DEPTH(4), .PAYLOAD_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .dbg_o (dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops expected words from exp_q while out_ready = 1, one per cycle.
  task automatic drain_and_check(input string name);
    int n;
    n = exp_q.size();
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check({name, "_valid"}, {7'd0, bus_if.out_valid}, 8'h01);
      check({name, "_word"}, bus_if.out_word, exp_q.pop_front());
      @(negedge clk);
    end
    check({name, "_empty_valid"}, {7'd0, bus_if.out_valid}, 8'h00);
    check({name, "_empty_word"}, bus_if.out_word, 8'h00);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus_if.ser_valid = 1'b0;
      bus_if.ser_in    = 1'b0;
    end
    @(negedge clk);
    bus_if.ser_in    = b;
    bus_if.ser_valid = 1'b1;
  endtask

  // Sends start, payload LSB first, parity, stop. Optional clear_err and/or
  // out_ready pulse on the stop-bit cycle. Returns at the negedge right after
  // the stop-bit edge, with the strobe dropped.
  task automatic send_frame(input logic [5:0] payload, input logic par, input logic stop,
                            input int gap, input logic clr_on_stop, input logic pop_on_stop);
    logic [8:0] bits;
    bits = {stop, par, payload, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive_bit(bits[i], gap);
      if (i == 8) begin
        bus_if.clear_err = clr_on_stop;
        if (pop_on_stop) bus_if.out_ready = 1'b1;
      end
    end
    @(negedge clk);
    bus_if.ser_valid = 1'b0;
    bus_if.ser_in    = 1'b0;
    bus_if.clear_err = 1'b0;
    if (pop_on_stop) bus_if.out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus_if.clear_err = 1'b1;
    @(negedge clk);
    bus_if.clear_err = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, {7'd0, bus_if.out_valid}, 8'h00);
    check({name, "_word"}, bus_if.out_word, 8'h00);
    check({name, "_err"}, {7'd0, bus_if.frame_err}, 8'h00);
    check({name, "_ovf"}, {4'd0, bus_if.overflow_cnt}, 8'h00);
    check({name, "_state"}, {6'd0, dbg.state}, {6'd0, IDLE});
    check({name, "_fifo_empty"}, {7'd0, dbg.fifo_empty}, 8'h01);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0] payload;
    logic       par;
    logic       stop;
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_word;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{6'h39, 1'b0, 1'b0, 0, 1'b1, 8'hF9, 1'b0}; // reference frame
    vecs[1] = '{6'h39, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1}; // parity error
    vecs[2] = '{6'h39, 1'b0, 1'b0, 3, 1'b1, 8'hF9, 1'b0}; // 3-cycle strobe gaps
    vecs[3] = '{6'h00, 1'b0, 1'b0, 1, 1'b1, 8'hC0, 1'b0};
    vecs[4] = '{6'h3F, 1'b0, 1'b0, 0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{6'h01, 1'b1, 1'b0, 0, 1'b1, 8'hC1, 1'b0};
    vecs[6] = '{6'h2A, 1'b1, 1'b0, 2, 1'b1, 8'hEA, 1'b0};
    vecs[7] = '{6'h01, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b1}; // stop-bit error
    vecs[8] = '{6'h03, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1}; // parity error, 2 ones

    rst_n            = 1'b1;
    bus_if.ser_in    = 1'b0;
    bus_if.ser_valid = 1'b0;
    bus_if.clear_err = 1'b0;
    bus_if.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // ---- table-driven single frames, out_ready held high ----
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse_clear();
      check($sformatf("v%0d_pre_err", i), {7'd0, bus_if.frame_err}, 8'h00);
      send_frame(vecs[i].payload, vecs[i].par, vecs[i].stop, vecs[i].gap, 1'b0, 1'b0);
      check($sformatf("v%0d_valid", i), {7'd0, bus_if.out_valid}, {7'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_word", i), bus_if.out_word, vecs[i].exp_word);
      check($sformatf("v%0d_err", i), {7'd0, bus_if.frame_err}, {7'd0, vecs[i].exp_err});
      @(negedge clk);
      check($sformatf("v%0d_after_valid", i), {7'd0, bus_if.out_valid}, 8'h00);
      check($sformatf("v%0d_after_word", i), bus_if.out_word, 8'h00);
    end

    // ---- clear_err coinciding with a new error: set wins ----
    pulse_clear();
    check("clr_pre_err", {7'd0, bus_if.frame_err}, 8'h00);
    send_frame(6'h39, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    check("clr_collide_err", {7'd0, bus_if.frame_err}, 8'h01);
    pulse_clear();
    check("clr_after_err", {7'd0, bus_if.frame_err}, 8'h00);

    // ---- overflow: 5 frames into a 4-deep FIFO with no pops ----
    bus_if.out_ready = 1'b0;
    send_frame(6'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h02, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h03, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h04, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h05, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("ovf_cnt", {4'd0, bus_if.overflow_cnt}, 8'h01);
    check("ovf_full", {7'd0, dbg.fifo_full}, 8'h01);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drain_and_check("ovf_drain");
    check("ovf_cnt_hold", {4'd0, bus_if.overflow_cnt}, 8'h01);

    // ---- full FIFO, stop bit lands with a pop: accepted, order kept ----
    bus_if.out_ready = 1'b0;
    send_frame(6'h06, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h08, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h09, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("sim_head_before", bus_if.out_word, 8'hC6);
    send_frame(6'h0A, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("sim_ovf_unchanged", {4'd0, bus_if.overflow_cnt}, 8'h01);
    check("sim_count", dbg.fifo_count, 8'h04);
    exp_q = '{8'hC7, 8'hC8, 8'hC9, 8'hCA};
    drain_and_check("sim_drain");

    // ---- overflow counter saturates at 15 ----
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_frame(6'h03, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("sat_ovf", {4'd0, bus_if.overflow_cnt}, 8'h0F);
    exp_q = '{8'hC3, 8'hC3, 8'hC3, 8'hC3};
    drain_and_check("sat_drain");

    // ---- reset mid-frame with pending word and error set ----
    bus_if.out_ready = 1'b0;
    send_frame(6'h05, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send_frame(6'h05, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("pre_rst_valid", {7'd0, bus_if.out_valid}, 8'h01);
    check("pre_rst_err", {7'd0, bus_if.frame_err}, 8'h01);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    @(negedge clk);
    bus_if.ser_valid = 1'b0;
    check("mid_state", {6'd0, dbg.state}, {6'd0, DATA});
    rst_n = 1'b1;
    #1;
    check_reset_values("mid_rst_async");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst_release");
    bus_if.out_ready = 1'b1;
    send_frame(6'h15, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_valid", {7'd0, bus_if.out_valid}, 8'h01);
    check("post_rst_word", bus_if.out_word, 8'hD5);
    check("post_rst_err", {7'd0, bus_if.frame_err}, 8'h00);
    @(negedge clk);
    check("post_rst_popped", {7'd0, bus_if.out_valid}, 8'h00);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
